// File: rtl/ascon_job_arbiter.sv
// ascon_job_arbiter: shares one ASCON engine between N_REQ requesters.
// Round-robin grant, one job in flight, watchdog abort for hung engine jobs.
module ascon_job_arbiter #(
  parameter int N_REQ   = 4,
  parameter int PT_W    = 1472,
  parameter int TIMEOUT = 4095
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ*PT_W-1:0]   pt_i,
  input  logic [N_REQ*128-1:0]    key_i,
  input  logic [N_REQ*128-1:0]    nonce_i,
  input  logic [N_REQ*64-1:0]     da_i,
  output logic [N_REQ-1:0]        grant_o,
  output logic [N_REQ-1:0]        done_o,
  output logic                    err_o,
  output logic [PT_W-1:0]         cipher_o,
  output logic [127:0]            tag_o,
  output logic                    busy_o,
  output logic                    eng_start_o,
  output logic [PT_W-1:0]         eng_pt_o,
  output logic [127:0]            eng_key_o,
  output logic [127:0]            eng_nonce_o,
  output logic [63:0]             eng_da_o,
  input  logic                    eng_done_i,
  input  logic [PT_W-1:0]         eng_cipher_i,
  input  logic [127:0]            eng_tag_i
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_r, state_s;
  logic [IDX_W-1:0]    rr_r, rr_s;
  logic [IDX_W-1:0]    idx_r, idx_s;
  logic [N_REQ-1:0]    grant_r, grant_s;
  logic [N_REQ-1:0]    done_r, done_s;
  logic                err_r, err_s;
  logic                start_r, start_s;
  logic [PT_W-1:0]     cipher_r, cipher_s;
  logic [127:0]        tag_r, tag_s;
  logic [WD_W-1:0]     wd_r, wd_s;
  logic [WD_W-1:0]     wd_inc_s;
  logic                timeout_s;
  logic [IDX_W:0]      pick_s;
  logic                sel_hit_s;
  logic [IDX_W-1:0]    sel_idx_s;

  // First requester at or above ptr (wrapping); returns {hit, index}.
  // Walking downward lets the lowest distance from ptr win without a break.
  function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] req,
                                             input logic [IDX_W-1:0] ptr);
    logic [IDX_W:0] res;
    int             k;
    res = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = int'(ptr) + i;
      if (k >= N_REQ) begin
        k = k - N_REQ;
      end else begin
        k = k;
      end
      if (req[k]) begin
        res = {1'b1, IDX_W'(k)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  assign pick_s    = rr_pick(req_i, rr_r);
  assign sel_hit_s = pick_s[IDX_W];
  assign sel_idx_s = pick_s[IDX_W-1:0];

  // wd_inc_s is the number of WAIT cycles including the current one, so the
  // abort fires after exactly TIMEOUT cycles spent in WAIT.
  assign wd_inc_s  = wd_r + WD_W'(1);
  assign timeout_s = (wd_inc_s == WD_W'(TIMEOUT));

  // State register.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: IDLE -> START -> WAIT -> DONE -> IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (sel_hit_s) state_s = START; else state_s = IDLE;
      START:   state_s = WAIT;
      WAIT:    if (eng_done_i || timeout_s) state_s = DONE; else state_s = WAIT;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Next values of the registered outputs and job bookkeeping.
  always_comb begin
    rr_s     = rr_r;
    idx_s    = idx_r;
    grant_s  = grant_r;
    done_s   = '0;
    err_s    = 1'b0;
    start_s  = 1'b0;
    cipher_s = cipher_r;
    tag_s    = tag_r;
    wd_s     = wd_r;
    case (state_r)
      IDLE: begin
        if (sel_hit_s) begin
          idx_s   = sel_idx_s;
          grant_s = N_REQ'(1'b1) << sel_idx_s;
          start_s = 1'b1;
        end else begin
          grant_s = '0;
        end
      end
      START: begin
        wd_s = '0;
      end
      WAIT: begin
        wd_s = wd_inc_s;
        // Engine completion beats a coincident watchdog expiry.
        if (eng_done_i) begin
          cipher_s = eng_cipher_i;
          tag_s    = eng_tag_i;
          done_s   = N_REQ'(1'b1) << idx_r;
        end else if (timeout_s) begin
          err_s  = 1'b1;
          done_s = N_REQ'(1'b1) << idx_r;
        end else begin
          done_s = '0;
        end
      end
      DONE: begin
        grant_s = '0;
        if (idx_r == IDX_W'(N_REQ - 1)) begin
          rr_s = '0;
        end else begin
          rr_s = idx_r + IDX_W'(1);
        end
      end
      default: begin
        grant_s = '0;
      end
    endcase
  end

  // Output and bookkeeping registers; reset abandons any job in flight.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      rr_r     <= '0;
      idx_r    <= '0;
      grant_r  <= '0;
      done_r   <= '0;
      err_r    <= 1'b0;
      start_r  <= 1'b0;
      cipher_r <= '0;
      tag_r    <= '0;
      wd_r     <= '0;
    end else begin
      rr_r     <= rr_s;
      idx_r    <= idx_s;
      grant_r  <= grant_s;
      done_r   <= done_s;
      err_r    <= err_s;
      start_r  <= start_s;
      cipher_r <= cipher_s;
      tag_r    <= tag_s;
      wd_r     <= wd_s;
    end
  end

  // Engine operand muxes driven only by the registered index and grant.
  always_comb begin
    eng_pt_o    = '0;
    eng_key_o   = '0;
    eng_nonce_o = '0;
    eng_da_o    = '0;
    if (|grant_r) begin
      eng_pt_o    = pt_i[int'(idx_r) * PT_W +: PT_W];
      eng_key_o   = key_i[int'(idx_r) * 128 +: 128];
      eng_nonce_o = nonce_i[int'(idx_r) * 128 +: 128];
      eng_da_o    = da_i[int'(idx_r) * 64 +: 64];
    end else begin
      eng_pt_o    = '0;
    end
  end

  assign grant_o     = grant_r;
  assign done_o      = done_r;
  assign err_o       = err_r;
  assign cipher_o    = cipher_r;
  assign tag_o       = tag_r;
  assign eng_start_o = start_r;
  assign busy_o      = (state_r != IDLE);

endmodule

// File: tb/tb_ascon_job_arbiter.sv
// Scoreboard bench for ascon_job_arbiter: two instances (default watchdog and
// TIMEOUT=15) with separate req/eng_done so each is exercised on its own.
module tb_ascon_job_arbiter;

  localparam int PT_W = 1472;

  typedef struct {
    logic [3:0]      vec;
    logic            err;
    logic [PT_W-1:0] d;
    logic [127:0]    t;
    logic [127:0]    n;
    logic [63:0]     a;
    int              cyc;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [3:0]         req_a = 4'd0, req_w = 4'd0;
  logic [4*PT_W-1:0]  pt;
  logic [511:0]       key, nonce;
  logic [255:0]       da;
  logic               eng_done_a = 1'b0, eng_done_w = 1'b0;
  logic [PT_W-1:0]    eng_cipher = '0;
  logic [127:0]       eng_tag = '0;

  logic [3:0]  grant_a, done_a, grant_w, done_w;
  logic        err_a, busy_a, start_a, err_w, busy_w, start_w;
  logic [PT_W-1:0] cipher_a, ept_a, cipher_w, ept_w;
  logic [127:0] tag_a, ekey_a, enonce_a, tag_w, ekey_w, enonce_w;
  logic [63:0]  eda_a, eda_w;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  exp_t q_start_a[$], q_done_a[$], q_start_w[$], q_done_w[$];

  ascon_job_arbiter u_dut (
    .clock_i(clk), .reset_i(rst_n), .req_i(req_a), .pt_i(pt), .key_i(key),
    .nonce_i(nonce), .da_i(da), .grant_o(grant_a), .done_o(done_a), .err_o(err_a),
    .cipher_o(cipher_a), .tag_o(tag_a), .busy_o(busy_a), .eng_start_o(start_a),
    .eng_pt_o(ept_a), .eng_key_o(ekey_a), .eng_nonce_o(enonce_a), .eng_da_o(eda_a),
    .eng_done_i(eng_done_a), .eng_cipher_i(eng_cipher), .eng_tag_i(eng_tag)
  );

  ascon_job_arbiter #(.N_REQ(4), .PT_W(PT_W), .TIMEOUT(15)) u_wd (
    .clock_i(clk), .reset_i(rst_n), .req_i(req_w), .pt_i(pt), .key_i(key),
    .nonce_i(nonce), .da_i(da), .grant_o(grant_w), .done_o(done_w), .err_o(err_w),
    .cipher_o(cipher_w), .tag_o(tag_w), .busy_o(busy_w), .eng_start_o(start_w),
    .eng_pt_o(ept_w), .eng_key_o(ekey_w), .eng_nonce_o(enonce_w), .eng_da_o(eda_w),
    .eng_done_i(eng_done_w), .eng_cipher_i(eng_cipher), .eng_tag_i(eng_tag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [PT_W-1:0] f_pt(input int k);
    return {46{32'hC0DE_0000 | 32'(k)}};
  endfunction
  function automatic logic [127:0] f_key(input int k);
    return {4{32'h4B00_0000 | 32'(k)}};
  endfunction
  function automatic logic [127:0] f_nonce(input int k);
    return {4{32'h4E00_0000 | 32'(k)}};
  endfunction
  function automatic logic [63:0] f_da(input int k);
    return {2{32'hDA00_0000 | 32'(k)}};
  endfunction

  task automatic chk(input string name, input logic [PT_W-1:0] act, input logic [PT_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (low 64 bits) at cycle %0d", name, act[63:0], exp[63:0], cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_start(input bit w, input int k, input int s);
    exp_t e;
    e.vec = 4'b0001 << k; e.err = 1'b0; e.d = f_pt(k); e.t = f_key(k);
    e.n = f_nonce(k); e.a = f_da(k); e.cyc = s;
    if (w) q_start_w.push_back(e); else q_start_a.push_back(e);
  endtask

  task automatic exp_done(input bit w, input int k, input logic err,
                          input logic [PT_W-1:0] c, input logic [127:0] t, input int at);
    exp_t e;
    e.vec = 4'b0001 << k; e.err = err; e.d = c; e.t = t;
    e.n = '0; e.a = '0; e.cyc = at;
    if (w) q_done_w.push_back(e); else q_done_a.push_back(e);
  endtask

  // Job granted at cycle s; engine done driven kd cycles later; returns in the done cycle.
  task automatic job(input bit w, input int k, input int s, input int kd,
                     input logic [PT_W-1:0] c, input logic [127:0] t);
    exp_start(w, k, s);
    exp_done(w, k, 1'b0, c, t, s + kd + 1);
    while (cyc < s + kd) tick();
    eng_cipher = c; eng_tag = t;
    if (w) eng_done_w = 1'b1; else eng_done_a = 1'b1;
    tick();
    eng_done_a = 1'b0; eng_done_w = 1'b0;
    eng_cipher = ~c; eng_tag = ~t;
  endtask

  task automatic chk_start(input string p, input bit have, input exp_t e, input logic st,
                           input logic [3:0] g, input logic [PT_W-1:0] d, input logic [127:0] k,
                           input logic [127:0] n, input logic [63:0] a, input logic b);
    if (!have) begin
      chk({p, "_start_unexpected"}, PT_W'(st), '0);
    end else begin
      chk({p, "_start_grant"}, PT_W'(g), PT_W'(e.vec));
      chk({p, "_start_cycle"}, PT_W'(cyc), PT_W'(e.cyc));
      chk({p, "_eng_pt"}, d, e.d);
      chk({p, "_eng_key"}, PT_W'(k), PT_W'(e.t));
      chk({p, "_eng_nonce"}, PT_W'(n), PT_W'(e.n));
      chk({p, "_eng_da"}, PT_W'(a), PT_W'(e.a));
      chk({p, "_start_busy"}, PT_W'(b), PT_W'(1'b1));
    end
  endtask

  task automatic chk_done(input string p, input bit have, input exp_t e, input logic [3:0] dn,
                          input logic er, input logic [PT_W-1:0] c, input logic [127:0] t,
                          input logic [3:0] g);
    if (!have) begin
      chk({p, "_done_unexpected"}, PT_W'(dn), '0);
    end else begin
      chk({p, "_done_vec"}, PT_W'(dn), PT_W'(e.vec));
      chk({p, "_done_err"}, PT_W'(er), PT_W'(e.err));
      chk({p, "_done_cycle"}, PT_W'(cyc), PT_W'(e.cyc));
      chk({p, "_cipher"}, c, e.d);
      chk({p, "_tag"}, PT_W'(t), PT_W'(e.t));
      chk({p, "_done_grant"}, PT_W'(g), PT_W'(e.vec));
    end
  endtask

  // Monitor: pops the scoreboard whenever either instance presents start or done.
  always @(negedge clk) begin
    exp_t e;
    bit   have;
    if (start_a) begin
      have = (q_start_a.size() != 0);
      if (have) e = q_start_a.pop_front();
      chk_start("a", have, e, start_a, grant_a, ept_a, ekey_a, enonce_a, eda_a, busy_a);
    end
    if (start_w) begin
      have = (q_start_w.size() != 0);
      if (have) e = q_start_w.pop_front();
      chk_start("w", have, e, start_w, grant_w, ept_w, ekey_w, enonce_w, eda_w, busy_w);
    end
    if (done_a != 4'd0) begin
      have = (q_done_a.size() != 0);
      if (have) e = q_done_a.pop_front();
      chk_done("a", have, e, done_a, err_a, cipher_a, tag_a, grant_a);
    end else begin
      chk("a_err_without_done", PT_W'(err_a), '0);
    end
    if (done_w != 4'd0) begin
      have = (q_done_w.size() != 0);
      if (have) e = q_done_w.pop_front();
      chk_done("w", have, e, done_w, err_w, cipher_w, tag_w, grant_w);
    end else begin
      chk("w_err_without_done", PT_W'(err_w), '0);
    end
  end

  task automatic chk_reset_a(input string p);
    chk({p, "_grant"}, PT_W'(grant_a), '0);
    chk({p, "_done"}, PT_W'(done_a), '0);
    chk({p, "_err"}, PT_W'(err_a), '0);
    chk({p, "_cipher"}, cipher_a, '0);
    chk({p, "_tag"}, PT_W'(tag_a), '0);
    chk({p, "_busy"}, PT_W'(busy_a), '0);
    chk({p, "_start"}, PT_W'(start_a), '0);
    chk({p, "_eng_pt"}, ept_a, '0);
    chk({p, "_eng_key"}, PT_W'(ekey_a), '0);
    chk({p, "_eng_nonce"}, PT_W'(enonce_a), '0);
    chk({p, "_eng_da"}, PT_W'(eda_a), '0);
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
  endtask

  initial begin
    int s;
    for (int k = 0; k < 4; k++) begin
      pt[k*PT_W +: PT_W] = f_pt(k);
      key[k*128 +: 128]  = f_key(k);
      nonce[k*128 +: 128] = f_nonce(k);
      da[k*64 +: 64]     = f_da(k);
    end
    // Reset state
    #2;
    chk_reset_a("rst0");
    chk("rst0_w_grant", PT_W'(grant_w), '0);
    chk("rst0_w_busy", PT_W'(busy_w), '0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();

    // Single job from requester 2, engine done 30 cycles after start
    req_a = 4'b0100; s = cyc + 1;
    job(1'b0, 2, s, 30, {46{32'h1234_5678}}, 128'hA5A5_0000_1111_2222_3333_4444_5555_6666);
    req_a = 4'd0;
    tick(); tick();

    // Reset in the middle of a WAIT job abandons it
    req_a = 4'b0001; s = cyc + 1;
    exp_start(1'b0, 0, s);
    while (cyc < s + 3) tick();
    rst_n = 1'b0; req_a = 4'd0;
    #2;
    chk_reset_a("rst_mid");
    tick(); tick(); tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    eng_cipher = {46{32'hBAD0_BAD0}}; eng_done_a = 1'b1;
    tick();
    eng_done_a = 1'b0;
    repeat (5) tick();
    chk("a_cipher_after_idle_done", cipher_a, '0);

    // Fairness: all four request continuously; order 0,1,2,3,0 from rr=0
    req_a = 4'b1111; s = cyc + 1;
    for (int j = 0; j < 5; j++) begin
      job(1'b0, j % 4, s, 3 + j, {46{32'hF000_0000 | 32'(j)}}, {4{32'hE000_0000 | 32'(j)}});
      s = cyc + 2;
    end
    req_a = 4'd0;
    repeat (3) tick();

    // Withdraw before grant (req 1) and drop after grant (req 3)
    req_a = 4'b0001; s = cyc + 1;
    exp_start(1'b0, 0, s);
    exp_done(1'b0, 0, 1'b0, {46{32'h0606_0606}}, 128'h6, s + 9);
    while (cyc < s + 2) tick();
    req_a = 4'b1011;
    tick(); tick();
    req_a = 4'b1001;
    while (cyc < s + 8) tick();
    eng_cipher = {46{32'h0606_0606}}; eng_tag = 128'h6; eng_done_a = 1'b1;
    tick();
    eng_done_a = 1'b0;
    req_a = 4'b1000;
    s = cyc + 2;
    while (cyc < s) tick();
    req_a = 4'd0;
    job(1'b0, 3, s, 5, {46{32'h0707_0707}}, 128'h7);
    repeat (10) tick();

    // Watchdog instance: engine done on the timeout cycle wins
    req_w = 4'b0010; s = cyc + 1;
    job(1'b1, 1, s, 15, {46{32'h0505_0505}}, 128'h55);
    req_w = 4'd0;
    tick(); tick();
    // Engine done in IDLE: no done, no capture (checked by the timeout job below)
    eng_cipher = {46{32'hDEAD_BEEF}}; eng_tag = 128'hDEAD; eng_done_w = 1'b1;
    tick();
    eng_done_w = 1'b0;
    tick(); tick();
    // Watchdog abort: done with err 16 cycles after start, results unchanged
    req_w = 4'b1000; s = cyc + 1;
    exp_start(1'b1, 3, s);
    exp_done(1'b1, 3, 1'b1, {46{32'h0505_0505}}, 128'h55, s + 16);
    while (cyc < s + 16) tick();
    req_w = 4'd0;
    repeat (5) tick();

    chk("q_start_a_empty", PT_W'(q_start_a.size()), '0);
    chk("q_done_a_empty", PT_W'(q_done_a.size()), '0);
    chk("q_start_w_empty", PT_W'(q_start_w.size()), '0);
    chk("q_done_w_empty", PT_W'(q_done_w.size()), '0);
    summary();
    $finish;
  end

  initial begin
    #1_000_000;
    n_bad++;
    $display("FAIL global_timeout: got still running want finished");
    summary();
    $finish;
  end

endmodule
